// File: rtl/sd_host_cmd_decoder_pkg.sv
// Shared types and codes for the SD host command decoder; SD_CKSUM_EN selects the 6-byte checksummed packet.
// Pure definitions: no latency or backpressure of its own.
package sd_host_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LATCH,
    S_CHECK,
    S_ADDR_RDY,
    S_CMD,
    S_WAIT_SD,
    S_STATUS
  } sd_dec_state_t;

  localparam logic [7:0] OP_READ    = 8'h52;
  localparam logic [7:0] OP_WRITE   = 8'h57;

  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_SD_ERR  = 8'h01;
  localparam logic [7:0] ST_SD_TMO  = 8'h02;
  localparam logic [7:0] ST_RX_TMO  = 8'h03;
  localparam logic [7:0] ST_BAD_OP  = 8'hE1;
  localparam logic [7:0] ST_BAD_CK  = 8'hE2;

`ifdef SD_CKSUM_EN
  localparam logic [2:0] PKT_LAST = 3'd5;
`else
  localparam logic [2:0] PKT_LAST = 3'd4;
`endif

  function automatic logic op_valid(input logic [7:0] op);
    return (op == OP_READ) || (op == OP_WRITE);
  endfunction

endpackage

// File: rtl/sd_host_cmd_decoder_if.sv
// USB FIFO and sd_interface signals seen by the command decoder.
// master = decoder side, slave = FIFOs / sd_interface side.
interface sd_host_cmd_decoder_if;
  logic        rx_fifo_empty;
  logic [7:0]  rx_data;
  logic        rx_r_enable;
  logic        tx_fifo_full;
  logic        tx_w_enable;
  logic [7:0]  tx_data;
  logic [31:0] sd_addr;
  logic        sd_addr_ready;
  logic        sd_read;
  logic        sd_write;
  logic        sd_done;
  logic        sd_err;
  logic        busy;

  modport master (
    input  rx_fifo_empty, rx_data, tx_fifo_full, sd_done, sd_err,
    output rx_r_enable, tx_w_enable, tx_data, sd_addr, sd_addr_ready,
           sd_read, sd_write, busy
  );

  modport slave (
    output rx_fifo_empty, rx_data, tx_fifo_full, sd_done, sd_err,
    input  rx_r_enable, tx_w_enable, tx_data, sd_addr, sd_addr_ready,
           sd_read, sd_write, busy
  );
endinterface

// File: rtl/sd_host_cmd_decoder_timer.sv
// Shared timeout counter: counts while enabled, rollover pulses on the TIMEOUT_CYCLES-th enabled cycle.
// Clear has priority over enable; no backpressure.
module sd_timeout_counter #(
  parameter  int unsigned TIMEOUT_CYCLES = 2_000_000,
  localparam int unsigned TMR_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic enable,
  output logic rollover
);

  localparam logic [TMR_W-1:0] CNT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  assign rollover = enable && !clear && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = rollover ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sd_host_cmd_decoder.sv
// Pops a host packet (opcode, 32-bit address, checksum when SD_CKSUM_EN), issues one SD command, pushes one status byte.
// Two cycles per RX byte when data is ready; stalls on empty RX (timeout) and waits indefinitely on full TX.
module sd_host_cmd_decoder
  import sd_host_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input logic                  clk,
  input logic                  n_rst,
  sd_host_cmd_decoder_if.master bus
);

  sd_dec_state_t state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    op_q, op_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   sd_addr_q, sd_addr_d;
  logic [7:0]    status_q, status_d;
  logic          rx_r_enable_q, rx_r_enable_d;
  logic          tx_w_enable_q, tx_w_enable_d;
  logic          sd_addr_ready_q, sd_addr_ready_d;
  logic          sd_read_q, sd_read_d;
  logic          sd_write_q, sd_write_d;
  logic          busy_q, busy_d;
`ifdef SD_CKSUM_EN
  logic [7:0]    ck_q, ck_d;
  logic          ck_ok_q, ck_ok_d;
`endif

  logic tmr_en, tmr_tmo;

  // One timer serves both the inter-byte gap and the SD wait; any other state clears it.
  assign tmr_en = (state_q == S_POP) || (state_q == S_WAIT_SD);

  sd_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmr (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear    (!tmr_en),
    .enable   (tmr_en),
    .rollover (tmr_tmo)
  );

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    op_d            = op_q;
    addr_d          = addr_q;
    sd_addr_d       = sd_addr_q;
    status_d        = status_q;
    rx_r_enable_d   = 1'b0;
    tx_w_enable_d   = 1'b0;
    sd_addr_ready_d = 1'b0;
    sd_read_d       = 1'b0;
    sd_write_d      = 1'b0;
`ifdef SD_CKSUM_EN
    ck_d            = ck_q;
    ck_ok_d         = ck_ok_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (!bus.rx_fifo_empty) begin
          state_d       = S_POP;
          rx_r_enable_d = 1'b1;
          idx_d         = 3'd0;
`ifdef SD_CKSUM_EN
          ck_d          = 8'h00;
          ck_ok_d       = 1'b0;
`endif
        end
      end

      // The pop strobe is decided a cycle ahead, so a POP cycle either carries the strobe or waits.
      S_POP: begin
        if (rx_r_enable_q) begin
          state_d = S_LATCH;
        end else if (!bus.rx_fifo_empty) begin
          rx_r_enable_d = 1'b1;
        end else if (tmr_tmo) begin
          state_d  = S_STATUS;
          status_d = ST_RX_TMO;
        end
      end

      S_LATCH: begin
        if (idx_q == 3'd0) begin
          op_d = bus.rx_data;
        end else if (idx_q <= 3'd4) begin
          addr_d = {addr_q[23:0], bus.rx_data};
        end
`ifdef SD_CKSUM_EN
        if (idx_q <= 3'd4) begin
          ck_d = ck_q ^ bus.rx_data;
        end else begin
          ck_ok_d = (bus.rx_data == ck_q);
        end
`endif
        if ((idx_q == 3'd0) && !op_valid(bus.rx_data)) begin
          state_d  = S_STATUS;
          status_d = ST_BAD_OP;
        end else if (idx_q == PKT_LAST) begin
          state_d = S_CHECK;
        end else begin
          idx_d         = idx_q + 3'd1;
          state_d       = S_POP;
          rx_r_enable_d = !bus.rx_fifo_empty;
        end
      end

      S_CHECK: begin
`ifdef SD_CKSUM_EN
        if (!ck_ok_q) begin
          state_d  = S_STATUS;
          status_d = ST_BAD_CK;
        end else begin
          state_d         = S_ADDR_RDY;
          sd_addr_ready_d = 1'b1;
          sd_addr_d       = addr_q;
        end
`else
        state_d         = S_ADDR_RDY;
        sd_addr_ready_d = 1'b1;
        sd_addr_d       = addr_q;
`endif
      end

      S_ADDR_RDY: begin
        state_d    = S_CMD;
        sd_read_d  = (op_q == OP_READ);
        sd_write_d = (op_q == OP_WRITE);
      end

      S_CMD: state_d = S_WAIT_SD;

      S_WAIT_SD: begin
        if (bus.sd_err) begin
          state_d  = S_STATUS;
          status_d = ST_SD_ERR;
        end else if (bus.sd_done) begin
          state_d  = S_STATUS;
          status_d = ST_OK;
        end else if (tmr_tmo) begin
          state_d  = S_STATUS;
          status_d = ST_SD_TMO;
        end
      end

      // The push is decided a cycle ahead; only this block writes the TX FIFO, so full cannot rise meanwhile.
      S_STATUS: begin
        if (tx_w_enable_q) begin
          state_d = S_IDLE;
        end else if (!bus.tx_fifo_full) begin
          tx_w_enable_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q         <= S_IDLE;
      idx_q           <= 3'd0;
      op_q            <= 8'h00;
      addr_q          <= 32'h0;
      sd_addr_q       <= 32'h0;
      status_q        <= 8'h00;
      rx_r_enable_q   <= 1'b0;
      tx_w_enable_q   <= 1'b0;
      sd_addr_ready_q <= 1'b0;
      sd_read_q       <= 1'b0;
      sd_write_q      <= 1'b0;
      busy_q          <= 1'b0;
`ifdef SD_CKSUM_EN
      ck_q            <= 8'h00;
      ck_ok_q         <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      op_q            <= op_d;
      addr_q          <= addr_d;
      sd_addr_q       <= sd_addr_d;
      status_q        <= status_d;
      rx_r_enable_q   <= rx_r_enable_d;
      tx_w_enable_q   <= tx_w_enable_d;
      sd_addr_ready_q <= sd_addr_ready_d;
      sd_read_q       <= sd_read_d;
      sd_write_q      <= sd_write_d;
      busy_q          <= busy_d;
`ifdef SD_CKSUM_EN
      ck_q            <= ck_d;
      ck_ok_q         <= ck_ok_d;
`endif
    end
  end

  assign bus.rx_r_enable   = rx_r_enable_q;
  assign bus.tx_w_enable   = tx_w_enable_q;
  assign bus.tx_data       = status_q;
  assign bus.sd_addr       = sd_addr_q;
  assign bus.sd_addr_ready = sd_addr_ready_q;
  assign bus.sd_read       = sd_read_q;
  assign bus.sd_write      = sd_write_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_sd_host_cmd_decoder.sv
// Scoreboard bench for sd_host_cmd_decoder: RX FIFO model, expected SD commands and status bytes queued at stimulus time.
module tb_sd_host_cmd_decoder;

  localparam int unsigned TMO = 250;
`ifdef SD_CKSUM_EN
  localparam int PKT_LEN = 6;
`else
  localparam int PKT_LEN = 5;
`endif

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  sd_host_cmd_decoder_if bus();

  sd_host_cmd_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_pop = 0, n_ardy = 0, n_rd = 0, n_wr = 0, n_tx = 0;

  logic [7:0]  rx_q[$];
  logic [7:0]  exp_tx[$];
  logic [31:0] exp_addr[$];
  logic [1:0]  exp_cmd[$];   // {read, write}

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // RX FIFO model and output monitor, both on the falling edge.
  always @(negedge clk) begin
    if (bus.rx_r_enable) begin
      n_pop++;
      if (rx_q.size() > 0) bus.rx_data = rx_q.pop_front();
      else chk("rx_underflow", bus.rx_fifo_empty, 1'b0);
    end
    bus.rx_fifo_empty = (rx_q.size() == 0);

    if (bus.sd_addr_ready) begin
      n_ardy++;
      if (exp_addr.size() > 0) chk("sd_addr", bus.sd_addr, exp_addr.pop_front());
      else chk("ardy_unexp", bus.sd_addr_ready, 1'b0);
    end
    if (bus.sd_read || bus.sd_write) begin
      if (bus.sd_read)  n_rd++;
      if (bus.sd_write) n_wr++;
      if (exp_cmd.size() > 0) chk("sd_cmd", {bus.sd_read, bus.sd_write}, exp_cmd.pop_front());
      else chk("cmd_unexp", {bus.sd_read, bus.sd_write}, 2'b00);
    end
    if (bus.tx_w_enable) begin
      n_tx++;
      if (exp_tx.size() > 0) chk("tx_data", bus.tx_data, exp_tx.pop_front());
      else chk("tx_unexp", bus.tx_w_enable, 1'b0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input logic [7:0] op, input logic [31:0] a);
    logic [7:0] ck;
    ck = op ^ a[31:24] ^ a[23:16] ^ a[15:8] ^ a[7:0];
    rx_q.push_back(op);
    rx_q.push_back(a[31:24]);
    rx_q.push_back(a[23:16]);
    rx_q.push_back(a[15:8]);
    rx_q.push_back(a[7:0]);
`ifdef SD_CKSUM_EN
    rx_q.push_back(ck);
`else
    if (ck == 8'h00) ck = 8'h01;
`endif
  endtask

  task automatic wait_cmd(input int target, input int budget, input string tag);
    int k = 0;
    while ((n_rd + n_wr) < target && k < budget) begin
      step();
      k++;
    end
    chk(tag, ((n_rd + n_wr) >= target), 1'b1);
  endtask

  task automatic wait_tx(input int target, input int budget, input string tag);
    int k = 0;
    while (n_tx < target && k < budget) begin
      step();
      k++;
    end
    chk(tag, (n_tx >= target), 1'b1);
  endtask

  task automatic pulse_sd(input logic d, input logic e);
    bus.sd_done = d;
    bus.sd_err  = e;
    step();
    bus.sd_done = 1'b0;
    bus.sd_err  = 1'b0;
  endtask

  initial begin
    #400_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1);
  end

  initial begin
    int p0, a0, r0, w0, t0, el;
    bus.tx_fifo_full = 1'b0;
    bus.sd_done      = 1'b0;
    bus.sd_err       = 1'b0;
    repeat (3) step();
    chk("rst_strobes", {bus.rx_r_enable, bus.tx_w_enable, bus.sd_addr_ready,
                        bus.sd_read, bus.sd_write, bus.busy}, 6'b0);
    chk("rst_addr", bus.sd_addr, 32'h0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (3) step();
    chk("idle_busy", bus.busy, 1'b0);

    // 1: read, sd_done 200 cycles after the command
    p0 = n_pop; a0 = n_ardy; r0 = n_rd; w0 = n_wr; t0 = n_tx;
    send_pkt(8'h52, 32'h0000_0100);
    exp_addr.push_back(32'h0000_0100); exp_cmd.push_back(2'b10); exp_tx.push_back(8'h00);
    wait_cmd(r0 + w0 + 1, 100, "t1_cmd_seen");
    chk("t1_busy_wait", bus.busy, 1'b1);
    repeat (200) step();
    chk("t1_no_early_tx", n_tx - t0, 0);
    pulse_sd(1'b1, 1'b0);
    wait_tx(t0 + 1, 20, "t1_tx_seen");
    chk("t1_pops", n_pop - p0, PKT_LEN);
    chk("t1_ardy_cnt", n_ardy - a0, 1);
    chk("t1_rd_cnt", n_rd - r0, 1);
    chk("t1_wr_cnt", n_wr - w0, 0);

    // 2: write, sd_err and sd_done together
    repeat (3) step();
    a0 = n_ardy; r0 = n_rd; w0 = n_wr; t0 = n_tx;
    send_pkt(8'h57, 32'h1234_5678);
    exp_addr.push_back(32'h1234_5678); exp_cmd.push_back(2'b01); exp_tx.push_back(8'h01);
    wait_cmd(r0 + w0 + 1, 100, "t2_cmd_seen");
    repeat (10) step();
    pulse_sd(1'b1, 1'b1);
    wait_tx(t0 + 1, 20, "t2_tx_seen");
    chk("t2_wr_cnt", n_wr - w0, 1);
    chk("t2_rd_cnt", n_rd - r0, 0);

    // 3: bad opcode, then a normal packet
    repeat (3) step();
    p0 = n_pop; a0 = n_ardy; r0 = n_rd; w0 = n_wr; t0 = n_tx;
    rx_q.push_back(8'h41);
    exp_tx.push_back(8'hE1);
    wait_tx(t0 + 1, 50, "t3_tx_seen");
    repeat (3) step();
    chk("t3_pops", n_pop - p0, 1);
    chk("t3_no_sd", (n_ardy - a0) + (n_rd - r0) + (n_wr - w0), 0);
    chk("t3_idle", bus.busy, 1'b0);
    send_pkt(8'h57, 32'hA5A5_A5A5);
    exp_addr.push_back(32'hA5A5_A5A5); exp_cmd.push_back(2'b01); exp_tx.push_back(8'h00);
    wait_cmd(r0 + w0 + 1, 100, "t3b_cmd_seen");
    pulse_sd(1'b1, 1'b0);
    wait_tx(t0 + 2, 20, "t3b_tx_seen");

    // 4a: SD timeout
    repeat (3) step();
    r0 = n_rd; w0 = n_wr; t0 = n_tx;
    send_pkt(8'h52, 32'hFFFF_FFFF);
    exp_addr.push_back(32'hFFFF_FFFF); exp_cmd.push_back(2'b10); exp_tx.push_back(8'h02);
    wait_cmd(r0 + w0 + 1, 100, "t4a_cmd_seen");
    el = 0;
    while (n_tx == t0 && el < int'(TMO) + 50) begin
      step();
      el++;
    end
    chk("t4a_tmo_window", (el >= int'(TMO)) && (el <= int'(TMO) + 3), 1'b1);

    // 4b: RX stall after three bytes
    repeat (3) step();
    p0 = n_pop; a0 = n_ardy; t0 = n_tx;
    rx_q.push_back(8'h52); rx_q.push_back(8'h00); rx_q.push_back(8'h00);
    exp_tx.push_back(8'h03);
    wait_tx(t0 + 1, int'(TMO) + 60, "t4b_tx_seen");
    chk("t4b_pops", n_pop - p0, 3);
    chk("t4b_no_ardy", n_ardy - a0, 0);

    // 5: TX FIFO full while status is pending
    repeat (3) step();
    r0 = n_rd; w0 = n_wr; t0 = n_tx;
    bus.tx_fifo_full = 1'b1;
    send_pkt(8'h52, 32'h0000_0ABC);
    exp_addr.push_back(32'h0000_0ABC); exp_cmd.push_back(2'b10); exp_tx.push_back(8'h00);
    wait_cmd(r0 + w0 + 1, 100, "t5_cmd_seen");
    pulse_sd(1'b1, 1'b0);
    repeat (50) step();
    chk("t5_held_off", n_tx - t0, 0);
    chk("t5_busy_held", bus.busy, 1'b1);
    bus.tx_fifo_full = 1'b0;
    wait_tx(t0 + 1, 10, "t5_tx_seen");
    repeat (5) step();
    chk("t5_one_push", n_tx - t0, 1);
    chk("t5_idle", bus.busy, 1'b0);

    // 6: asynchronous reset while waiting on the SD side
    r0 = n_rd; w0 = n_wr; t0 = n_tx;
    send_pkt(8'h52, 32'h0BAD_F00D);
    exp_addr.push_back(32'h0BAD_F00D); exp_cmd.push_back(2'b10);
    wait_cmd(r0 + w0 + 1, 100, "t6_cmd_seen");
    repeat (5) step();
    #2;
    n_rst = 1'b0;
    #1;
    chk("t6_rst_strobes", {bus.rx_r_enable, bus.tx_w_enable, bus.sd_addr_ready,
                           bus.sd_read, bus.sd_write, bus.busy}, 6'b0);
    chk("t6_rst_addr", bus.sd_addr, 32'h0);
    @(negedge clk);
    n_rst = 1'b1;
    pulse_sd(1'b1, 1'b0);
    repeat (20) step();
    chk("t6_no_status", n_tx - t0, 0);
    chk("t6_idle", bus.busy, 1'b0);

`ifdef SD_CKSUM_EN
    // Bad checksum: status only, no SD command
    r0 = n_rd; w0 = n_wr; a0 = n_ardy; t0 = n_tx;
    rx_q.push_back(8'h52); rx_q.push_back(8'h00); rx_q.push_back(8'h00);
    rx_q.push_back(8'h01); rx_q.push_back(8'h00); rx_q.push_back(8'h54);
    exp_tx.push_back(8'hE2);
    wait_tx(t0 + 1, 100, "ck_tx_seen");
    chk("ck_no_sd", (n_rd - r0) + (n_wr - w0) + (n_ardy - a0), 0);
`endif

    repeat (5) step();
    chk("sb_drained", exp_tx.size() + exp_addr.size() + exp_cmd.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
